// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu - multi-cycle ALU sharing one start/done handshake.
//
// Single-cycle ops (logic, add/sub, shifts, rotates) finish one cycle after
// acceptance; signed MUL (radix-2 Booth) and signed DIV (restoring, on
// magnitudes) take WIDTH iteration cycles plus a finish cycle. The 2*WIDTH
// result {HI, LO} and div_zero are registered and held until the next done.
//
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   request, sampled only while busy=0
//   op        in   [4:0] operation code, sampled with start
//   A, B      in   [WIDTH-1:0] operands, sampled with start
//   busy      out  operation in progress
//   done      out  one-cycle pulse, result valid
//   result    out  [2*WIDTH-1:0] {HI, LO}
//   div_zero  out  DIV had B=0, held with result
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [4:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero
);

    localparam logic [4:0] OP_OR   = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_NEG  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHRA = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_DIV  = 5'd11;
    localparam logic [4:0] OP_INC  = 5'd12;
    localparam logic [4:0] OP_NOT  = 5'd13;

    localparam int                 CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW:0]       W_AMT    = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH:0]       acc_q, acc_d;     // Booth accumulator / division remainder
    logic [WIDTH-1:0]     lo_q, lo_d;       // multiplier / dividend-quotient shifter
    logic                 qb_q, qb_d;       // Booth q(-1) bit
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div_zero_q, div_zero_d;

    // Datapath helpers
    logic [SHW-1:0]       amt;
    logic [SHW:0]         inv_amt;
    logic [WIDTH-1:0]     alu_r;
    logic [WIDTH:0]       a_ext, booth_sum, mul_acc;
    logic [WIDTH-1:0]     mul_lo;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       rem_sh, div_diff, div_acc;
    logic [WIDTH-1:0]     div_lo;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        amt     = b_q[SHW-1:0];
        // Complementary amount for rotates; amount 0 gives WIDTH, which shifts
        // everything out so A passes unchanged.
        inv_amt = W_AMT - {1'b0, amt};

        alu_r = a_q & b_q;
        case (op_q)
            OP_OR:   alu_r = a_q | b_q;
            OP_AND:  alu_r = a_q & b_q;
            OP_ADD:  alu_r = a_q + b_q;
            OP_SUB:  alu_r = a_q - b_q;
            OP_NEG:  alu_r = -b_q;
            OP_SHR:  alu_r = a_q >> amt;
            OP_SHL:  alu_r = a_q << amt;
            OP_ROR:  alu_r = (a_q >> amt) | (a_q << inv_amt);
            OP_ROL:  alu_r = (a_q << amt) | (a_q >> inv_amt);
            OP_SHRA: alu_r = $signed(a_q) >>> amt;
            OP_INC:  alu_r = b_q + ONE_W;
            OP_NOT:  alu_r = ~b_q;
            default: alu_r = a_q & b_q;
        endcase

        // Booth radix-2: examine {multiplier LSB, q(-1)}, add/sub the
        // sign-extended multiplicand, then arithmetic-shift {acc, lo} right.
        a_ext     = {a_q[WIDTH-1], a_q};
        booth_sum = acc_q;
        case ({lo_q[0], qb_q})
            2'b10:   booth_sum = acc_q - a_ext;
            2'b01:   booth_sum = acc_q + a_ext;
            default: booth_sum = acc_q;
        endcase
        mul_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo  = {booth_sum[0], lo_q[WIDTH-1:1]};

        // Restoring division on magnitudes; the most-negative value's magnitude
        // still fits WIDTH bits when read as unsigned.
        b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
        rem_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, b_mag};
        div_acc  = div_diff[WIDTH] ? rem_sh : div_diff;
        div_lo   = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

        // Quotient negative when signs differ; remainder follows the dividend.
        quo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -lo_q : lo_q;
        rem_fix = a_q[WIDTH-1] ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        qb_d       = qb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = A;
                    b_d    = B;
                    busy_d = 1'b1;
                    acc_d  = '0;
                    qb_d   = 1'b0;
                    cnt_d  = '0;
                    if (op == OP_MUL) begin
                        lo_d    = B;
                        state_d = S_ITER;
                    end else if (op == OP_DIV) begin
                        lo_d    = A[WIDTH-1] ? -A : A;
                        state_d = S_ITER;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + ONE_C;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    lo_d  = mul_lo;
                    qb_d  = lo_q[0];
                end else begin
                    acc_d = div_acc;
                    lo_d  = div_lo;
                end
                if (cnt_q == LAST_CNT) state_d = S_FIN;
            end
            S_FIN: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                cnt_d      = '0;
                div_zero_d = 1'b0;
                if (op_q == OP_MUL) begin
                    result_d = {acc_q[WIDTH-1:0], lo_q};
                end else if (op_q == OP_DIV) begin
                    if (b_q == '0) begin
                        result_d   = {a_q, {WIDTH{1'b1}}};
                        div_zero_d = 1'b1;
                    end else begin
                        result_d = {rem_fix, quo_fix};
                    end
                end else begin
                    result_d = {{WIDTH{alu_r[WIDTH-1]}}, alu_r};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    // NOTE: operand and shifter registers are reset along with the control
    // state, so nothing in the block ever carries X after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            qb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            qb_q       <= qb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu - self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
// Expected values come from an arithmetic reference model (native signed
// multiply, divide and modulo on 64-bit integers).
// -----------------------------------------------------------------------------
module tb_seq_alu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic        start_32, busy_32, done_32, div_zero_32;
    logic [4:0]  op_32;
    logic [31:0] a_32, b_32;
    logic [63:0] result_32;

    logic        start_8, busy_8, done_8, div_zero_8;
    logic [4:0]  op_8;
    logic [7:0]  a_8, b_8;
    logic [15:0] result_8;

    seq_alu #(.WIDTH(32)) dut_32 (
        .clock(clock), .reset_n(reset_n), .start(start_32), .op(op_32),
        .A(a_32), .B(b_32), .busy(busy_32), .done(done_32),
        .result(result_32), .div_zero(div_zero_32)
    );

    seq_alu #(.WIDTH(8)) dut_8 (
        .clock(clock), .reset_n(reset_n), .start(start_8), .op(op_8),
        .A(a_8), .B(b_8), .busy(busy_8), .done(done_8),
        .result(result_8), .div_zero(div_zero_8)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [64:0] last_res [2];   // {div_zero, result} last seen per instance

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sext(input logic [63:0] v, input int w);
        return $signed(v << (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic [64:0] model(input int w, input logic [4:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] m, m2, a, b, r, hi, lo;
        longint sa, sb;
        int amt;
        m  = (64'd1 << w) - 64'd1;
        m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        a  = a_in & m;
        b  = b_in & m;
        sa = sext(a, w);
        sb = sext(b, w);
        amt = int'(b[5:0]) % w;
        if (op == 5'd10) return {1'b0, 64'(sa * sb) & m2};
        if (op == 5'd11) begin
            if (sb == 0) return {1'b1, (a << w) | m};
            lo = 64'(sa / sb) & m;
            hi = 64'(sa % sb) & m;
            return {1'b0, (hi << w) | lo};
        end
        case (op)
            5'd0:    r = a | b;
            5'd2:    r = a + b;
            5'd3:    r = a - b;
            5'd4:    r = -b;
            5'd5:    r = a >> amt;
            5'd6:    r = a << amt;
            5'd7:    r = (a >> amt) | (a << (w - amt));
            5'd8:    r = (a << amt) | (a >> (w - amt));
            5'd9:    r = 64'(sa >>> amt);
            5'd12:   r = b + 64'd1;
            5'd13:   r = ~b;
            default: r = a & b;
        endcase
        return {1'b0, 64'(sext(r & m, w)) & m2};
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic s_busy(input bit w8);
        return w8 ? busy_8 : busy_32;
    endfunction
    function automatic logic s_done(input bit w8);
        return w8 ? done_8 : done_32;
    endfunction
    function automatic logic [64:0] s_res(input bit w8);
        return w8 ? {div_zero_8, 48'd0, result_8} : {div_zero_32, result_32};
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            start_8 = st; op_8 = op; a_8 = a[7:0]; b_8 = b[7:0];
        end else begin
            start_32 = st; op_32 = op; a_32 = a[31:0]; b_32 = b[31:0];
        end
    endtask

    function automatic logic [63:0] rnd_val(input int w);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'd1 << (w - 1);
            4:       return (64'd1 << (w - 1)) - 64'd1;
            5:       return 64'($urandom_range(0, 40));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One transaction: accept, optional pokes while busy, then check latency,
    // result, div_zero, and that outputs held their old values until done.
    task automatic do_op(input bit w8, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input bit b2b, input bit poke,
                         output logic [64:0] got);
        int w, lat, k;
        logic [64:0] exp;
        bit seen, stable;
        w   = w8 ? 8 : 32;
        lat = (op == 5'd10 || op == 5'd11) ? w + 1 : 1;
        exp = model(w, op, a, b);
        seen = 1'b0;
        stable = 1'b1;
        if (!b2b) begin
            @(negedge clock);
            check("done_pulse", 64'(s_done(w8)), 64'd0);
        end
        drive(w8, 1'b1, op, a, b);
        @(posedge clock);
        @(negedge clock);
        check("busy_on", 64'(s_busy(w8)), 64'd1);
        check("done_early", 64'(s_done(w8)), 64'd0);
        k = 1;
        while (k <= lat + 4 && !seen) begin
            if (poke && k <= lat)
                drive(w8, 1'b1, 5'd10, rnd_val(w), rnd_val(w));
            else
                drive(w8, 1'b0, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clock);
            if (s_done(w8)) begin
                seen = 1'b1;
            end else begin
                if (s_res(w8) !== last_res[w8] || s_busy(w8) !== 1'b1) stable = 1'b0;
                k++;
            end
        end
        drive(w8, 1'b0, 5'd0, 64'd0, 64'd0);
        got = s_res(w8);
        check("latency", 64'(k), 64'(lat));
        check("result", got[63:0], exp[63:0]);
        check("div_zero", 64'(got[64]), 64'(exp[64]));
        check("busy_off", 64'(s_busy(w8)), 64'd0);
        check("hold", 64'(stable), 64'd1);
        last_res[w8] = got;
    endtask

    task automatic abort_div();
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 5'd11, 64'(-17), 64'd5);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_32), 64'd0);
        check("abort_done", 64'(done_32), 64'd0);
        check("abort_result", result_32, 64'd0);
        check("abort_dz", 64'(div_zero_32), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (done_32) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        last_res[0] = '0;
        last_res[1] = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] got;
        logic [4:0]  rop;
        last_res[0] = '0;
        last_res[1] = '0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 5'd0, 64'd0, 64'd0);
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy_32), 64'd0);
        check("rst_done", 64'(done_32), 64'd0);
        check("rst_result", result_32, 64'd0);
        check("rst_dz", 64'(div_zero_32), 64'd0);
        check("rst_result8", 64'(result_8), 64'd0);
        reset_n = 1'b1;

        // Directed vectors at WIDTH=32
        do_op(1'b0, 5'd2, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, got);
        check("add_wrap", got[63:0], 64'hFFFF_FFFF_8000_0000);
        do_op(1'b0, 5'd10, 64'(-7), 64'd3, 1'b1, 1'b0, got);
        check("mul_neg", got[63:0], 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(1'b0, 5'd10, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b0, got);
        check("mul_minmin", got[63:0], 64'h4000_0000_0000_0000);
        do_op(1'b0, 5'd11, 64'(-17), 64'd5, 1'b0, 1'b0, got);
        check("div_neg_a", got[63:0], 64'hFFFF_FFFE_FFFF_FFFD);
        do_op(1'b0, 5'd11, 64'd17, 64'(-5), 1'b1, 1'b0, got);
        check("div_neg_b", got[63:0], 64'h0000_0002_FFFF_FFFD);
        do_op(1'b0, 5'd11, 64'd9, 64'd0, 1'b0, 1'b0, got);
        check("div_zero_res", got[63:0], 64'h0000_0009_FFFF_FFFF);
        check("div_zero_flag", 64'(got[64]), 64'd1);
        do_op(1'b0, 5'd11, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, got);
        check("div_minneg1", got[63:0], 64'h0000_0000_8000_0000);
        do_op(1'b0, 5'd7, 64'd1, 64'd33, 1'b1, 1'b0, got);
        check("ror_33", got[63:0], 64'hFFFF_FFFF_8000_0000);
        do_op(1'b0, 5'd9, 64'h8000_0000, 64'd31, 1'b1, 1'b0, got);
        check("shra_31", got[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(1'b0, 5'd8, 64'h8765_4321, 64'd32, 1'b0, 1'b0, got);
        do_op(1'b0, 5'd6, 64'h1234_5678, 64'd0, 1'b0, 1'b0, got);
        do_op(1'b0, 5'd20, 64'hF0F0_1234, 64'h0FF0_FFFF, 1'b0, 1'b0, got);
        do_op(1'b0, 5'd10, 64'd123456, 64'(-789), 1'b0, 1'b1, got);
        check("mul_poke", got[63:0], 64'(-97406784));

        abort_div();

        // Randomized mix at WIDTH=32
        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 9) < 4) ? 5'(10 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            do_op(1'b0, rop, rnd_val(32), rnd_val(32), 1'($urandom_range(0, 1)), 1'b0, got);
        end

        // WIDTH=8 instance
        do_op(1'b1, 5'd10, 64'h80, 64'h80, 1'b0, 1'b0, got);
        check("mul8_minmin", got[63:0], 64'h4000);
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 9) < 5) ? 5'(10 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            do_op(1'b1, rop, rnd_val(8), rnd_val(8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the datapath, the successor to the combinational 32-bit ALU. Single-cycle operations and iterative signed multiply/divide share one start/done handshake, so the control unit stalls only on MUL/DIV. The block registers its 2×WIDTH result, which feeds the HI/LO and Z register path directly.

## Interface

- WIDTH, 32: operand width; power of two, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount bits, taken from B[SHW-1:0].
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- start  in  1  request; sampled only when busy=0.
- op  in  5  operation code; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  2*WIDTH  {HI, LO}; held until the next accepted start.
- div_zero  out  1  set with done when DIV had B=0; held with result.

## Operation

- Op codes: 0 OR, 1 AND, 2 ADD, 3 SUB (A−B), 4 NEG (−B), 5 SHR logical, 6 SHL, 7 ROR, 8 ROL, 9 SHRA, 10 MUL, 11 DIV, 12 INC (B+1), 13 NOT (~B), 14–31 AND.
- Ops 0–9, 12, 13: WIDTH-bit result, sign-extended to 2*WIDTH; ADD/SUB/INC/NEG wrap with no overflow flag.
- Shift/rotate amount = B[SHW-1:0]; amount 0 passes A unchanged; rotates wrap modulo WIDTH.
- MUL: signed two's-complement, full 2*WIDTH product; one partial-product step per cycle (radix-2, Booth or equivalent).
- DIV: signed; quotient in LO, remainder in HI; truncate toward zero; remainder takes the dividend's sign; one restoring step per cycle on magnitudes, sign fix-up in the final step.
- DIV by zero: LO = all ones, HI = A; div_zero=1; normal latency.
- Most-negative / −1 DIV: LO = most-negative (wrap), HI = 0, div_zero=0.
- FSM: IDLE → (start, op not MUL/DIV) → FIN; IDLE → (start, MUL/DIV) → ITER; ITER counts WIDTH steps → FIN; FIN → IDLE. FIN asserts done.
- Operands and op are latched on acceptance; later input changes have no effect.

## Timing

- Reset values: busy=0, done=0, result=0, div_zero=0, FSM=IDLE, counter=0.
- Start accepted at edge N (busy=0): busy=1 from N.
- Single-cycle ops: done=1 and result valid in cycle N+1; busy=0 in cycle N+1.
- MUL/DIV: done=1 and result valid in cycle N+WIDTH+1; busy=1 for cycles N..N+WIDTH.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted.
- start while busy=1 is ignored entirely; no queuing.
- result/div_zero update only in the done cycle; stable at all other times.
- reset_n low mid-operation: immediate abort to reset values; no done pulse.

## Test plan

- ADD 0x7FFFFFFF + 1 (WIDTH=32) → done at N+1, result = 0xFFFFFFFF_80000000.
- MUL A=−7, B=3 → done exactly at N+33, result = 0xFFFFFFFF_FFFFFFEB; also 0x80000000×0x80000000 → 0x40000000_00000000.
- DIV A=−17, B=5 → LO = −3 (0xFFFFFFFD), HI = −2 (0xFFFFFFFE), div_zero=0; A=17, B=−5 → LO = −3, HI = 2.
- DIV A=9, B=0 → LO = 0xFFFFFFFF, HI = 9, div_zero=1, done at N+33.
- ROR A=0x00000001, B=33 → amount 1, result LO = 0x80000000, HI = all ones; SHRA 0x80000000 by 31 → all ones.
- start with new operands during busy MUL → ignored, original product returned; reset_n low at cycle N+10 of DIV → busy=0, result=0, no done pulse; rerun at WIDTH=8 with MUL −128×−128 → 0x4000.
